// File: rtl/expr_eval_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : expr_eval_sched_if
// Brief    : Request, datapath and response bundle for expr_eval_sched.
//            slave  = scheduler side, master = stimulus/datapath side.
// Revision : 1.0 - initial release
// ============================================================================
interface expr_eval_sched_if #(
  parameter int NREQ = 4
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*60-1:0] req_opnd;
  logic [59:0]        dp_opnd;
  logic [89:0]        dp_y;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [89:0]        rsp_y;

  modport slave (
    input  req_valid, req_opnd, dp_y, rsp_ready,
    output req_ready, dp_opnd, rsp_valid, rsp_id, rsp_y
  );

  modport master (
    output req_valid, req_opnd, dp_y, rsp_ready,
    input  req_ready, dp_opnd, rsp_valid, rsp_id, rsp_y
  );
endinterface
`default_nettype wire

// File: rtl/expr_eval_sched.sv
`default_nettype none
// ============================================================================
// Module   : expr_eval_sched
// Brief    : Round-robin scheduler sharing one combinational expression
//            datapath among NREQ requesters. One operation outstanding at a
//            time: arbitrate, register operands, wait LAT cycles, capture y,
//            return it with the requester ID on a valid/ready channel.
//            Optional macro EXPR_SCHED_STATS_EN builds a saturating
//            completed-response counter on stat_done (tied to 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module expr_eval_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  expr_eval_sched_if.slave    bus,
  output logic                busy,
  output logic [15:0]         stat_done
);
  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT_C = 4'(LAT);

  logic [1:0]     r_state;
  logic [1:0]     w_next_state;
  logic [IDW-1:0] r_last_grant;
  logic [IDW-1:0] r_cur_id;
  logic [IDW-1:0] w_winner;
  logic           w_found;
  logic [3:0]     r_cnt;
  logic [59:0]    r_dp_opnd;
  logic [89:0]    r_rsp_y;
  logic [IDW-1:0] r_rsp_id;
  logic           w_req_hs;
  logic           w_rsp_hs;

  // Cyclic priority search starting just after the last served requester.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(r_last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && bus.req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = IDW'(idx);
      end
    end
  end

  // The grant is only ever raised on a valid line, so a grant is a handshake.
  assign w_req_hs = (r_state == S_IDLE) && w_found;
  assign w_rsp_hs = (r_state == S_RESP) && bus.rsp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_req_hs) w_next_state = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next_state = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state: one-hot grant in IDLE, valid in RESP.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_found) bus.req_ready[w_winner] = 1'b1;
      end
      S_RESP:  bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand launch, settle countdown, result capture and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= IDW'(NREQ - 1);
      r_cur_id     <= '0;
      r_cnt        <= 4'd0;
      r_dp_opnd    <= '0;
      r_rsp_y      <= '0;
      r_rsp_id     <= '0;
    end else begin
      if (w_req_hs) begin
        r_dp_opnd <= bus.req_opnd[60*w_winner +: 60];
        r_cur_id  <= w_winner;
        r_cnt     <= LAT_C;
      end
      if (r_state == S_WAIT) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_rsp_y  <= bus.dp_y;
          r_rsp_id <= r_cur_id;
        end
      end
      if (w_rsp_hs) r_last_grant <= r_cur_id;
    end
  end

  assign bus.dp_opnd = r_dp_opnd;
  assign bus.rsp_y   = r_rsp_y;
  assign bus.rsp_id  = r_rsp_id;

`ifdef EXPR_SCHED_STATS_EN
  logic [15:0] r_stat_done;

  // Saturating count of accepted responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_stat_done <= 16'h0;
    else if (w_rsp_hs && r_stat_done != 16'hFFFF) r_stat_done <= r_stat_done + 16'h1;
  end

  assign stat_done = r_stat_done;
`else
  assign stat_done = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_expr_eval_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_expr_eval_sched
// Brief    : Self-checking bench for expr_eval_sched (LAT=2 main instance,
//            LAT=0 second instance). Expected results are queued when a
//            grant handshake is seen and compared when responses appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_expr_eval_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc   = 0;
  logic        busy, busy0;
  logic [15:0] stat_done, stat_done0;
  int          n_checks = 0;
  int          n_pass   = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [89:0] y;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  expr_eval_sched_if #(.NREQ(NREQ)) bus ();
  expr_eval_sched_if #(.NREQ(NREQ)) bus0 ();

  expr_eval_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy), .stat_done(stat_done)
  );

  expr_eval_sched #(.NREQ(NREQ), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .busy(busy0), .stat_done(stat_done0)
  );

  // Stand-in for the expression block: any fixed function of the operands.
  function automatic logic [89:0] expr_model(input logic [59:0] x);
    return ({x[29:0], x} ^ {x, x[59:30]}) + 90'h3;
  endfunction

  assign bus.dp_y  = expr_model(bus.dp_opnd);
  assign bus0.dp_y = expr_model(bus0.dp_opnd);

  // Scoreboard push on every request handshake of the main instance.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i])
          sb.push_back('{id: 2'(i), y: expr_model(bus.req_opnd[60*i +: 60])});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input bit use0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (use0 ? bus0.rsp_valid : bus.rsp_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) ok = 1'b1;
    end
  endtask

  task automatic accept(input bit use0);
    tick();
    if (use0) bus0.rsp_ready = 1'b1; else bus.rsp_ready = 1'b1;
    tick();
    if (use0) bus0.rsp_ready = 1'b0; else bus.rsp_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic run_op();
    bit ok;
    tick();
    bus.req_valid = 4'b0001;
    @(negedge clk);
    tick();
    bus.req_valid = 4'b0000;
    wait_rsp(1'b0, 20, ok);
    accept(1'b0);
  endtask

  task automatic test_reset();
    bus.req_valid  = '0; bus.req_opnd  = '0; bus.rsp_ready  = 1'b0;
    bus0.req_valid = '0; bus0.req_opnd = '0; bus0.rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); else n_pass++;
    n_checks++; if (bus.rsp_y !== 90'h0) $display("FAIL reset_rsp_y: got %0h want 0", bus.rsp_y); else n_pass++;
    n_checks++; if (bus.dp_opnd !== 60'h0) $display("FAIL reset_dp_opnd: got %0h want 0", bus.dp_opnd); else n_pass++;
    n_checks++; if (bus.req_ready !== 4'b0) $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); else n_pass++;
    n_checks++; if (stat_done !== 16'h0) $display("FAIL reset_stat_done: got %0h want 0", stat_done); else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit          ok;
    int          t;
    exp_t        e;
    logic [59:0] v = 60'h123456789ABCDEF;
    tick();
    bus.req_opnd[59:0] = v;
    bus.req_valid      = 4'b0001;
    @(negedge clk);
    t = cyc;
    n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    n_checks++; if (bus.dp_opnd !== v) $display("FAIL single_dp_opnd: got %0h want %0h", bus.dp_opnd, v); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %0b want 1", busy); else n_pass++;
    wait_rsp(1'b0, 20, ok);
    n_checks++; if (!ok) $display("FAIL single_timeout: got no rsp_valid want rsp_valid"); else n_pass++;
    n_checks++; if (cyc - t !== LAT + 2) $display("FAIL single_latency: got %0d want %0d", cyc - t, LAT + 2); else n_pass++;
    n_checks++; if (bus.rsp_id !== 2'd0) $display("FAIL single_rsp_id: got %0d want 0", bus.rsp_id); else n_pass++;
    n_checks++; if (bus.rsp_y !== expr_model(v)) $display("FAIL single_rsp_y: got %0h want %0h", bus.rsp_y, expr_model(v)); else n_pass++;
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    n_checks++; if ({bus.rsp_id, bus.rsp_y} !== {e.id, e.y}) $display("FAIL single_sb: got %0h want %0h", {bus.rsp_id, bus.rsp_y}, e); else n_pass++;
    accept(1'b0);
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_idle: got valid=%0b busy=%0b want 0 0", bus.rsp_valid, busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit   ok;
    int   prev = -1;
    exp_t e;
    pulse_reset();
    for (int i = 0; i < NREQ; i++) bus.req_opnd[60*i +: 60] = 60'({$urandom(), $urandom()});
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(20, ok);
      n_checks++; if (!ok) $display("FAIL rr_timeout: got no grant want grant %0d", k % 4); else n_pass++;
      n_checks++; if (bus.req_ready !== 4'(1 << (k % 4))) $display("FAIL rr_order: got %b want %b", bus.req_ready, 4'(1 << (k % 4))); else n_pass++;
      if (prev >= 0) begin
        n_checks++; if (cyc - prev !== LAT + 3) $display("FAIL rr_spacing: got %0d want %0d", cyc - prev, LAT + 3); else n_pass++;
      end
      prev = cyc;
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 4'b0) $display("FAIL rr_grant_width: got %b want 0000", bus.req_ready); else n_pass++;
      if (k == 4) bus.req_valid = 4'b0000;
      wait_rsp(1'b0, 20, ok);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      n_checks++; if (!ok || {bus.rsp_id, bus.rsp_y} !== {2'(k % 4), e.y}) $display("FAIL rr_rsp: got %0h want %0h", {bus.rsp_id, bus.rsp_y}, {2'(k % 4), e.y}); else n_pass++;
    end
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit          ok;
    bit          stable = 1'b1;
    exp_t        e;
    logic [89:0] y0;
    logic [1:0]  id0;
    tick();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b0100) $display("FAIL bp_grant: got %b want 0100", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 4'b1111;
    wait_rsp(1'b0, 20, ok);
    y0  = bus.rsp_y;
    id0 = bus.rsp_id;
    e   = (sb.size() > 0) ? sb.pop_front() : '0;
    n_checks++; if (!ok || {id0, y0} !== {2'd2, e.y}) $display("FAIL bp_rsp: got %0h want %0h", {id0, y0}, {2'd2, e.y}); else n_pass++;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== y0 || bus.rsp_id !== id0 || bus.req_ready !== 4'b0) stable = 1'b0;
    end
    n_checks++; if (!stable) $display("FAIL bp_hold: got changing outputs want stable"); else n_pass++;
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b0) $display("FAIL bp_accept_cycle: got %b want 0000", bus.req_ready); else n_pass++;
    tick();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b1000) $display("FAIL bp_next_grant: got %b want 1000", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 4'b0000;
    wait_rsp(1'b0, 20, ok);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    n_checks++; if (!ok || {bus.rsp_id, bus.rsp_y} !== {2'd3, e.y}) $display("FAIL bp_rsp2: got %0h want %0h", {bus.rsp_id, bus.rsp_y}, {2'd3, e.y}); else n_pass++;
    accept(1'b0);
  endtask

  task automatic test_reset_mid_wait();
    bit   ok;
    bit   quiet = 1'b1;
    exp_t e;
    tick();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 4'b0100) $display("FAIL rw_grant: got %b want 0100", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) $display("FAIL rw_async_state: got busy=%0b valid=%0b want 0 0", busy, bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.dp_opnd !== 60'h0 || bus.rsp_y !== 90'h0 || bus.rsp_id !== 2'd0) $display("FAIL rw_async_regs: got %0h %0h %0d want 0 0 0", bus.dp_opnd, bus.rsp_y, bus.rsp_id); else n_pass++;
    sb.delete();
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) quiet = 1'b0;
    end
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    n_checks++; if (!quiet || bus.req_ready !== 4'b0100) $display("FAIL rw_regrant: got quiet=%0b grant=%b want 1 0100", quiet, bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 4'b0000;
    wait_rsp(1'b0, 20, ok);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    n_checks++; if (!ok || {bus.rsp_id, bus.rsp_y} !== {2'd2, e.y}) $display("FAIL rw_rsp: got %0h want %0h", {bus.rsp_id, bus.rsp_y}, {2'd2, e.y}); else n_pass++;
    accept(1'b0);
  endtask

  task automatic test_lat0();
    bit          ok;
    int          t;
    logic [59:0] v = 60'hFEDCBA987654321;
    tick();
    bus0.req_opnd[119:60] = v;
    bus0.req_valid        = 4'b0010;
    @(negedge clk);
    t = cyc;
    n_checks++; if (bus0.req_ready !== 4'b0010) $display("FAIL lat0_grant: got %b want 0010", bus0.req_ready); else n_pass++;
    tick();
    bus0.req_valid = 4'b0000;
    wait_rsp(1'b1, 20, ok);
    n_checks++; if (!ok || cyc - t !== 2) $display("FAIL lat0_latency: got %0d want 2", cyc - t); else n_pass++;
    n_checks++; if (bus0.rsp_id !== 2'd1 || bus0.rsp_y !== expr_model(v)) $display("FAIL lat0_rsp: got %0d/%0h want 1/%0h", bus0.rsp_id, bus0.rsp_y, expr_model(v)); else n_pass++;
    accept(1'b1);
  endtask

  task automatic test_stats();
`ifdef EXPR_SCHED_STATS_EN
    pulse_reset();
    repeat (3) run_op();
    @(negedge clk);
    n_checks++; if (stat_done !== 16'd3) $display("FAIL stats_count: got %0d want 3", stat_done); else n_pass++;
    force dut.r_stat_done = 16'hFFFF;
    tick();
    release dut.r_stat_done;
    run_op();
    @(negedge clk);
    n_checks++; if (stat_done !== 16'hFFFF) $display("FAIL stats_saturate: got %0h want ffff", stat_done); else n_pass++;
`else
    run_op();
    @(negedge clk);
    n_checks++; if (stat_done !== 16'h0 || stat_done0 !== 16'h0) $display("FAIL stats_tied: got %0h/%0h want 0/0", stat_done, stat_done0); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_wait();
    test_lat0();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
